// File: rtl/overdrive_pkg.sv
// Shared types and constants for the overdrive saturator initiator.
// Contents: FSM state enum, unity gains, Q1.15 saturation limits, gain clamp.
// Used by overdrive_driver and q_mul_shift.
package overdrive_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREGAIN,
      ST_WAIT,
      ST_POSTGAIN,
      ST_MIX
   } state_t;

   localparam logic [7:0]        DRIVE_UNITY = 8'h10;
   localparam logic [8:0]        GAIN_UNITY  = 9'd256;
   localparam logic signed [15:0] SAT_MAX    = 16'sh7FFF;
   // Symmetric range: -32768 is never produced so the tanh core sees a balanced input.
   localparam logic signed [15:0] SAT_MIN    = -16'sh7FFF;

   function automatic logic [8:0] clamp_gain(input logic [8:0] g);
      return (g > GAIN_UNITY) ? GAIN_UNITY : g;
   endfunction

endpackage

// File: rtl/q_mul_shift.sv
// Signed x unsigned multiply, arithmetic right shift, optional Q1.15 saturation.
// Latency: combinational. Backpressure: none.
// Ports: a_i signed operand, b_i unsigned gain, y_o 16-bit signed result.
module q_mul_shift
   import overdrive_pkg::*;
#(
   parameter int AW    = 16,
   parameter int BW    = 8,
   parameter int SHIFT = 4,
   parameter bit SAT   = 1'b0
) (
   input  logic signed [AW-1:0] a_i,
   input  logic        [BW-1:0] b_i,
   output logic signed [15:0]   y_o
);

   // Signed times zero-extended unsigned never needs more than AW+BW bits.
   localparam int PW = AW + BW;
   localparam logic signed [PW-1:0] HI = PW'(SAT_MAX);
   localparam logic signed [PW-1:0] LO = PW'(SAT_MIN);

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;

   always_comb begin
      a_ext   = {{BW{a_i[AW-1]}}, a_i};
      b_ext   = {{AW{1'b0}}, b_i};
      prod    = a_ext * b_ext;
      shifted = prod >>> SHIFT;
      if (SAT && (shifted > HI)) begin
         y_o = SAT_MAX;
      end else if (SAT && (shifted < LO)) begin
         y_o = SAT_MIN;
      end else begin
         y_o = 16'(shifted);
      end
   end

endmodule

// File: rtl/overdrive_driver.sv
// Overdrive initiator: drive gain + saturate, tanh core handshake, level gain and dry/wet mix.
// Latency: accept->tanh_din_valid 2 cycles; tanh_dout_valid->sample_out_valid 3 cycles.
// Backpressure: none upstream; one-deep pending slot, overwrite sets sticky overrun.
// Ports: sample_in/_valid in, drive/level/mix controls, clear_flags, tanh_* handshake,
//        sample_out/_valid out, busy, overrun, timeout.
module overdrive_driver
   import overdrive_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TIMEOUT_W      = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic        [15:0] sample_in,
   input  logic               sample_in_valid,
   input  logic        [7:0]  drive,
   input  logic        [8:0]  level,
   input  logic        [8:0]  mix,
   input  logic               clear_flags,
   output logic        [15:0] tanh_din,
   output logic               tanh_din_valid,
   input  logic        [15:0] tanh_dout,
   input  logic               tanh_dout_valid,
   output logic        [15:0] sample_out,
   output logic               sample_out_valid,
   output logic               busy,
   output logic               overrun,
   output logic               timeout
);

   localparam int DRIVE_FRAC = $clog2(DRIVE_UNITY);
   localparam int GAIN_FRAC  = $clog2(GAIN_UNITY);
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic signed [15:0]    dry_q, dry_d;
   logic        [7:0]     drive_q, drive_d;
   logic        [8:0]     level_q, level_d;
   logic        [8:0]     mix_q, mix_d;
   logic                  pend_vld_q, pend_vld_d;
   logic        [15:0]    pend_dat_q, pend_dat_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic signed [15:0]    tanh_res_q, tanh_res_d;
   logic signed [15:0]    wet_q, wet_d;
   logic        [15:0]    tanh_din_q, tanh_din_d;
   logic                  tanh_din_vld_q, tanh_din_vld_d;
   logic        [15:0]    sample_out_q, sample_out_d;
   logic                  sample_out_vld_q, sample_out_vld_d;
   logic                  overrun_q, overrun_d;
   logic                  timeout_q, timeout_d;

   logic signed [15:0]    pre_sat;
   logic signed [15:0]    wet_mul;
   logic        [8:0]     inv_mix;
   logic signed [25:0]    mix_acc;
   logic signed [15:0]    mix_out;
   logic                  take;
   logic        [15:0]    take_dat;
   logic                  ovr_set;
   logic                  to_set;

   q_mul_shift #(.AW(16), .BW(8), .SHIFT(DRIVE_FRAC), .SAT(1'b1)) u_pregain (
      .a_i (dry_q),
      .b_i (drive_q),
      .y_o (pre_sat)
   );

   q_mul_shift #(.AW(16), .BW(9), .SHIFT(GAIN_FRAC), .SAT(1'b0)) u_postgain (
      .a_i (tanh_res_q),
      .b_i (level_q),
      .y_o (wet_mul)
   );

   // Crossfade; mix_q <= 256 so the weighted sum stays inside 25 bits.
   always_comb begin
      inv_mix = GAIN_UNITY - mix_q;
      mix_acc = $signed({{10{wet_q[15]}}, wet_q}) * $signed({17'd0, mix_q})
              + $signed({{10{dry_q[15]}}, dry_q}) * $signed({17'd0, inv_mix});
      mix_out = 16'(mix_acc >>> GAIN_FRAC);
   end

   always_comb begin
      state_d          = state_q;
      dry_d            = dry_q;
      drive_d          = drive_q;
      level_d          = level_q;
      mix_d            = mix_q;
      pend_vld_d       = pend_vld_q;
      pend_dat_d       = pend_dat_q;
      cnt_d            = cnt_q;
      tanh_res_d       = tanh_res_q;
      wet_d            = wet_q;
      tanh_din_d       = tanh_din_q;
      tanh_din_vld_d   = 1'b0;
      sample_out_d     = sample_out_q;
      sample_out_vld_d = 1'b0;
      ovr_set          = 1'b0;
      to_set           = 1'b0;
      // An older pending sample always goes ahead of a fresh one.
      take             = pend_vld_q | sample_in_valid;
      take_dat         = pend_vld_q ? pend_dat_q : sample_in;

      case (state_q)
         ST_IDLE: begin
            if (take) begin
               dry_d   = take_dat;
               drive_d = drive;
               level_d = clamp_gain(level);
               mix_d   = clamp_gain(mix);
               state_d = ST_PREGAIN;
            end
         end
         ST_PREGAIN: begin
            tanh_din_d     = pre_sat;
            tanh_din_vld_d = 1'b1;
            cnt_d          = '0;
            state_d        = ST_WAIT;
         end
         ST_WAIT: begin
            if (tanh_dout_valid) begin
               tanh_res_d = tanh_dout;
               state_d    = ST_POSTGAIN;
            end else if (cnt_q == CNT_LAST) begin
               // Core gave up on: pass the dry sample through so the stream keeps its rate.
               to_set           = 1'b1;
               sample_out_d     = dry_q;
               sample_out_vld_d = 1'b1;
               state_d          = ST_IDLE;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         ST_POSTGAIN: begin
            wet_d   = wet_mul;
            state_d = ST_MIX;
         end
         ST_MIX: begin
            sample_out_d     = mix_out;
            sample_out_vld_d = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Pending slot: in IDLE a full slot is drained and simultaneously refilled
      // by a new arrival, which is not an overrun.
      if (sample_in_valid) begin
         if (state_q != ST_IDLE) begin
            pend_vld_d = 1'b1;
            pend_dat_d = sample_in;
            ovr_set    = pend_vld_q;
         end else if (pend_vld_q) begin
            pend_dat_d = sample_in;
         end
      end else if ((state_q == ST_IDLE) && pend_vld_q) begin
         pend_vld_d = 1'b0;
      end

      overrun_d = (overrun_q & ~clear_flags) | ovr_set;
      timeout_d = (timeout_q & ~clear_flags) | to_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         dry_q            <= '0;
         drive_q          <= '0;
         level_q          <= '0;
         mix_q            <= '0;
         pend_vld_q       <= 1'b0;
         pend_dat_q       <= '0;
         cnt_q            <= '0;
         tanh_res_q       <= '0;
         wet_q            <= '0;
         tanh_din_q       <= '0;
         tanh_din_vld_q   <= 1'b0;
         sample_out_q     <= '0;
         sample_out_vld_q <= 1'b0;
         overrun_q        <= 1'b0;
         timeout_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         dry_q            <= dry_d;
         drive_q          <= drive_d;
         level_q          <= level_d;
         mix_q            <= mix_d;
         pend_vld_q       <= pend_vld_d;
         pend_dat_q       <= pend_dat_d;
         cnt_q            <= cnt_d;
         tanh_res_q       <= tanh_res_d;
         wet_q            <= wet_d;
         tanh_din_q       <= tanh_din_d;
         tanh_din_vld_q   <= tanh_din_vld_d;
         sample_out_q     <= sample_out_d;
         sample_out_vld_q <= sample_out_vld_d;
         overrun_q        <= overrun_d;
         timeout_q        <= timeout_d;
      end
   end

   assign tanh_din         = tanh_din_q;
   assign tanh_din_valid   = tanh_din_vld_q;
   assign sample_out       = sample_out_q;
   assign sample_out_valid = sample_out_vld_q;
   assign busy             = (state_q != ST_IDLE);
   assign overrun          = overrun_q;
   assign timeout          = timeout_q;

endmodule

// File: tb/tb_overdrive_driver.sv
// Bench for overdrive_driver: tanh core responder, event-timed reference model,
// per-cycle output compare, directed literal checks and a randomized run.
module tb_overdrive_driver;

   localparam int TO = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] sample_in = '0;
   logic        sample_in_valid = 1'b0;
   logic [7:0]  drive = 8'h10;
   logic [8:0]  level = 9'd256;
   logic [8:0]  mix = 9'd256;
   logic        clear_flags = 1'b0;
   logic [15:0] tanh_din;
   logic        tanh_din_valid;
   logic [15:0] tanh_dout = '0;
   logic        tanh_dout_valid = 1'b0;
   logic [15:0] sample_out;
   logic        sample_out_valid;
   logic        busy;
   logic        overrun;
   logic        timeout;

   always #5 clk = ~clk;

   overdrive_driver #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(9)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .drive            (drive),
      .level            (level),
      .mix              (mix),
      .clear_flags      (clear_flags),
      .tanh_din         (tanh_din),
      .tanh_din_valid   (tanh_din_valid),
      .tanh_dout        (tanh_dout),
      .tanh_dout_valid  (tanh_dout_valid),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .busy             (busy),
      .overrun          (overrun),
      .timeout          (timeout)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   int tcyc = 0;
   always @(posedge clk) tcyc++;

   // ---------------- tanh core responder ----------------
   int          rsp_delay = 5;
   bit          rsp_rand = 0;
   logic [15:0] rsp_val = '0;
   int          r_cnt = 0;
   logic [15:0] r_val = '0;
   int          ans_cyc = 0;

   always @(posedge clk) begin
      bit fire;
      fire = 1'b0;
      if (!rst_n) begin
         r_cnt = 0;
      end else begin
         if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) fire = 1'b1;
         end
         if (tanh_din_valid) begin
            if (rsp_rand) begin
               r_cnt = ($urandom_range(0, 39) == 0) ? 270 : int'($urandom_range(1, 30));
               r_val = 16'($urandom);
            end else begin
               r_cnt = rsp_delay;
               r_val = rsp_val;
            end
         end
      end
      #2;
      tanh_dout_valid = fire;
      if (fire) begin
         tanh_dout = r_val;
         ans_cyc   = tcyc;
      end
   end

   // ---------------- reference model ----------------
   function automatic int f_pre(input int d, input int g);
      int p;
      p = (d * g) >>> 4;
      if (p > 32767) p = 32767;
      if (p < -32767) p = -32767;
      return p;
   endfunction

   function automatic int f_mix(input int d, input int a, input int l, input int m);
      int wet;
      wet = (a * l) >>> 8;
      return (wet * m + d * (256 - m)) >>> 8;
   endfunction

   int          cyc;
   bit          j_act, j_ans;
   int          j_din_edge, j_out_edge, j_dry, j_drive, j_level, j_mix, j_res;
   bit          p_vld;
   logic [15:0] p_dat;
   bit          m_busy, m_din_vld, m_out_vld, m_ovr, m_to;
   logic [15:0] m_din, m_out;

   task automatic m_start(input logic [15:0] s);
      j_act      = 1'b1;
      j_ans      = 1'b0;
      j_din_edge = cyc + 1;
      j_dry      = int'($signed(s));
      j_drive    = int'(drive);
      j_level    = (level > 9'd256) ? 256 : int'(level);
      j_mix      = (mix > 9'd256) ? 256 : int'(mix);
   endtask

   always @(posedge clk) begin
      bit was_idle, ovr_set, to_set;
      if (!rst_n) begin
         cyc = 0; j_act = 0; j_ans = 0; p_vld = 0; p_dat = '0;
         m_busy = 0; m_din_vld = 0; m_out_vld = 0; m_ovr = 0; m_to = 0;
         m_din = '0; m_out = '0;
      end else begin
         cyc++;
         m_din_vld = 0; m_out_vld = 0; ovr_set = 0; to_set = 0;
         was_idle = !j_act;
         if (j_act) begin
            if (cyc == j_din_edge) begin
               m_din_vld = 1;
               m_din = 16'(f_pre(j_dry, j_drive));
            end else if (!j_ans) begin
               if (tanh_dout_valid) begin
                  j_ans      = 1;
                  j_out_edge = cyc + 2;
                  j_res      = f_mix(j_dry, int'($signed(tanh_dout)), j_level, j_mix);
               end else if (cyc == j_din_edge + TO) begin
                  m_out_vld = 1; m_out = 16'(j_dry); to_set = 1; j_act = 0;
               end
            end else if (cyc == j_out_edge) begin
               m_out_vld = 1; m_out = 16'(j_res); j_act = 0;
            end
         end
         if (was_idle) begin
            if (p_vld) begin
               m_start(p_dat);
               p_vld = sample_in_valid;
               p_dat = sample_in;
            end else if (sample_in_valid) begin
               m_start(sample_in);
            end
         end else if (sample_in_valid) begin
            if (p_vld) ovr_set = 1;
            p_vld = 1;
            p_dat = sample_in;
         end
         if (clear_flags) begin m_ovr = 0; m_to = 0; end
         if (ovr_set) m_ovr = 1;
         if (to_set) m_to = 1;
         m_busy = j_act;
      end
   end

   // ---------------- per-cycle compare + event log ----------------
   bit          chk_en = 1'b0;
   int          din_cyc = 0, out_cyc = 0, out_cnt = 0;
   logic [15:0] din_val = '0, out_val = '0;
   logic [15:0] outs[$];

   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_din_vld", tanh_din_valid, 0);
            chk("rst_din", tanh_din, 0);
            chk("rst_out_vld", sample_out_valid, 0);
            chk("rst_out", sample_out, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_timeout", timeout, 0);
         end else begin
            chk("busy", busy, m_busy);
            chk("din_vld", tanh_din_valid, m_din_vld);
            chk("din", tanh_din, m_din);
            chk("out_vld", sample_out_valid, m_out_vld);
            chk("out", sample_out, m_out);
            chk("overrun", overrun, m_ovr);
            chk("timeout", timeout, m_to);
         end
      end
      if (tanh_din_valid) begin din_cyc = tcyc; din_val = tanh_din; end
      if (sample_out_valid) begin
         out_cyc = tcyc; out_val = sample_out; out_cnt++;
         outs.push_back(sample_out);
      end
   end

   // ---------------- stimulus ----------------
   int in_cyc = 0;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [15:0] s, input logic [7:0] d, input logic [8:0] l,
                       input logic [8:0] m);
      sample_in = s; drive = d; level = l; mix = m;
      sample_in_valid = 1'b1;
      in_cyc = tcyc;
      tick();
      sample_in_valid = 1'b0;
   endtask

   task automatic wait_outs(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (out_cnt < target && n < budget) begin
         tick();
         n++;
      end
      chk(name, out_cnt, target);
   endtask

   task automatic pulse_clear();
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
   endtask

   initial begin
      int base;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      #2;
      chk("reset_busy", busy, 0);
      chk("reset_out_vld", sample_out_valid, 0);
      chk("reset_din_vld", tanh_din_valid, 0);
      chk("reset_flags", {overrun, timeout}, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // Unity path: 0x1000 with drive 1.0, core returns 0x0F00.
      rsp_delay = 20; rsp_val = 16'h0F00;
      send(16'h1000, 8'h10, 9'd256, 9'd256);
      wait_outs("t1_out", 1, 100);
      chk("t1_din", din_val, 16'h1000);
      chk("t1_din_lat", din_cyc - in_cyc, 2);
      chk("t1_out_val", out_val, 16'h0F00);
      chk("t1_out_lat", out_cyc - ans_cyc, 3);
      tick();

      // Pre-gain saturation, both polarities.
      rsp_delay = 3; rsp_val = 16'h0100;
      send(16'h4000, 8'hFF, 9'd256, 9'd256);
      wait_outs("t2a_out", 2, 100);
      chk("t2a_din_sat", din_val, 16'h7FFF);
      send(16'hC000, 8'hFF, 9'd256, 9'd256);
      wait_outs("t2b_out", 3, 100);
      chk("t2b_din_sat", din_val, 16'h8001);

      // Dry-only mix, then half level with floor rounding.
      rsp_val = 16'h7777;
      send(16'h1234, 8'h10, 9'd256, 9'd0);
      wait_outs("t3a_out", 4, 100);
      chk("t3a_dry", out_val, 16'h1234);
      rsp_val = 16'h2000;
      send(16'h0100, 8'h10, 9'd128, 9'd256);
      wait_outs("t3b_out", 5, 100);
      chk("t3b_half", out_val, 16'h1000);
      rsp_val = 16'hFFFD;
      send(16'h0100, 8'h10, 9'd128, 9'd256);
      wait_outs("t3c_out", 6, 100);
      chk("t3c_floor", out_val, 16'hFFFE);

      // Overrun: second sample overwritten by the third while the core is slow.
      rsp_delay = 50;
      pulse_clear();
      base = out_cnt;
      send(16'h0111, 8'h10, 9'd256, 9'd0);
      repeat (5) tick();
      send(16'h0222, 8'h10, 9'd256, 9'd0);
      repeat (3) tick();
      send(16'h0333, 8'h10, 9'd256, 9'd0);
      chk("t4_overrun_set", overrun, 1);
      wait_outs("t4_outs", base + 2, 300);
      repeat (80) tick();
      chk("t4_no_third", out_cnt, base + 2);
      chk("t4_first", outs[base], 16'h0111);
      chk("t4_second", outs[base + 1], 16'h0333);
      pulse_clear();
      chk("t4_overrun_clr", overrun, 0);

      // Timeout: the core answers far too late; the late answer must be dropped.
      rsp_delay = 300; rsp_val = 16'h1111;
      send(16'h5A5A, 8'h10, 9'd256, 9'd256);
      wait_outs("t5_out", base + 3, 400);
      chk("t5_timeout", timeout, 1);
      chk("t5_dry", out_val, 16'h5A5A);
      chk("t5_lat", out_cyc - din_cyc, TO);
      repeat (60) tick();
      chk("t5_late_ignored", out_cnt, base + 3);
      chk("t5_idle", busy, 0);
      pulse_clear();
      chk("t5_timeout_clr", timeout, 0);

      // Reset while waiting on the core.
      rsp_delay = 40; rsp_val = 16'h2222;
      send(16'h0321, 8'h10, 9'd256, 9'd256);
      repeat (10) tick();
      chk("t6_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_out", {sample_out_valid, sample_out}, 0);
      chk("t6_din", {tanh_din_valid, tanh_din}, 0);
      tick();
      rst_n = 1'b1;
      base = out_cnt;
      repeat (60) tick();
      chk("t6_no_out", out_cnt, base);
      rsp_delay = 5; rsp_val = 16'h0ABC;
      send(16'h0400, 8'h10, 9'd256, 9'd256);
      wait_outs("t6_next", base + 1, 100);
      chk("t6_next_din", din_val, 16'h0400);
      chk("t6_next_out", out_val, 16'h0ABC);

      // Randomized traffic against the model.
      rsp_rand = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         sample_in_valid = ($urandom_range(0, 15) == 0);
         sample_in       = 16'($urandom);
         drive           = 8'($urandom);
         level           = 9'($urandom);
         mix             = 9'($urandom);
         clear_flags     = ($urandom_range(0, 63) == 0);
         tick();
      end
      sample_in_valid = 1'b0;
      clear_flags     = 1'b0;
      repeat (700) tick();
      chk("rand_drained", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
